seq_sample_fifo: RTL and testbench

//  Downstream capture stage for the free-running 8-bit counter. Buffers one

---
 rtl/seq_sample_fifo.sv | 66 ++++++
 tb/tb_seq_sample_fifo.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_sample_fifo.sv
// seq_sample_fifo: show-ahead sample FIFO with drop counting; define SEQ_SAMPLE_FIFO_GAP_CHECK_EN to enable sequence-gap checking
module seq_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic                  gap_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] level_next;
  logic full, push, pop;
  assign full = level == (DEPTH_LOG2+1)'(DEPTH);
  assign pop = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign out_data = mem[rd_ptr];
  always_comb level_next = level + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      out_valid <= level_next != '0;
      if (in_valid && !push) begin
        overflow <= 1'b1;
        drop_count <= drop_count == 16'hFFFF ? drop_count : drop_count + 16'd1;
      end
    end
  end
`ifdef SEQ_SAMPLE_FIFO_GAP_CHECK_EN
  logic [WIDTH-1:0] prev;
  logic seen;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      seen <= 1'b0;
      gap_err <= 1'b0;
    end else if (in_valid) begin
      prev <= in_data;
      seen <= 1'b1;
      if (seen && in_data != WIDTH'(prev + 1'b1)) gap_err <= 1'b1;
    end
  end
`else
  assign gap_err = 1'b0;
`endif
endmodule

// File: tb/tb_seq_sample_fifo.sv
// tb_seq_sample_fifo: directed and random stimulus against a queue-based reference model
module tb_seq_sample_fifo;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, out_valid, overflow, gap_err;
  logic [7:0] in_data, out_data;
  logic [4:0] level;
  logic [15:0] drop_count;
  int n_checks = 0, n_fail = 0;
  logic [7:0] q [$];
  bit m_ovf, m_gap, m_seen;
  int m_drops;
  logic [7:0] m_prev;
  int cnt;

  seq_sample_fifo dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count), .gap_err(gap_err)
  );

  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task cyc(input bit r, input bit v, input logic [7:0] d, input bit rd);
    bit p, s;
    rst = r;
    in_valid = v;
    in_data = d;
    out_ready = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_drops = 0;
      m_gap = 0;
      m_seen = 0;
    end else begin
      p = q.size() > 0 && rd;
      s = v && (q.size() < 16 || p);
      if (p) void'(q.pop_front());
      if (s) q.push_back(d);
      if (v && !s) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
`ifdef SEQ_SAMPLE_FIFO_GAP_CHECK_EN
      if (v) begin
        if (m_seen && d != 8'(m_prev + 8'd1)) m_gap = 1;
        m_prev = d;
        m_seen = 1;
      end
`endif
    end
    #1;
    check("level", level, q.size());
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) check("out_data", out_data, q[0]);
    else if (r) check("out_data_rst", out_data, 0);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    check("gap_err", gap_err, m_gap);
  endtask

  initial begin
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i), 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 1, 8'(i), 0);
    check("full_drop", drop_count, 1);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cyc(0, 1, 8'(cnt), 0); cnt++; end
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 8'(cnt), 1); cnt++; end
    check("full_flow_level", level, 16);
    for (int i = 0; i < 7; i++) begin cyc(0, 1, 8'(cnt), 0); cnt++; end
    cyc(1, 1, 8'(cnt), 0);
    cyc(0, 1, 8'd99, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 8'd10, 1);
    cyc(0, 1, 8'd11, 1);
    cyc(0, 1, 8'd13, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 8'd254, 1);
    cyc(0, 1, 8'd255, 1);
    cyc(0, 1, 8'd0, 1);
    cyc(0, 1, 8'd1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 40; i++) cyc(0, 1, 8'(i + 200), 1);
    check("stream_level", level, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(199) == 0, $urandom_range(3) != 0, 8'($urandom),
          ((i / 64) % 2 == 0) ? $urandom_range(3) != 0 : $urandom_range(3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
